// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with 1-cycle latency and bubble-clean control bits.
// Define PIPE_STAGE_SKID_EN to add a skid register and a registered InReady.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 69,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [1:0]        Count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q;
`endif
    logic              accept;
    logic              pop;

    assign accept = InValid && InReady;
    assign pop    = OutValid && OutReady;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= (state_d != TWO);
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
`endif
        // Flush empties the stage but leaves main_data_q untouched so OutData holds.
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = InData;
                        main_ctrl_d = InCtrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_d = InData;
                        main_ctrl_d = InCtrl;
                    end else if (pop) begin
                        state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        state_d     = TWO;
                        skid_data_d = InData;
                        skid_ctrl_d = InCtrl;
`endif
                    end
                end
                TWO: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        OutValid = (state_q != EMPTY);
        OutData  = main_data_q;
        OutCtrl  = OutValid ? main_ctrl_q : '0;
        case (state_q)
            ONE:     Count = 2'd1;
            TWO:     Count = 2'd2;
            default: Count = 2'd0;
        endcase
`ifdef PIPE_STAGE_SKID_EN
        InReady = in_ready_q && !Reset;
`else
        InReady = (!OutValid || OutReady) && !Reset;
`endif
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid; follows PIPE_STAGE_SKID_EN to pick the expected behaviour.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 69;
    localparam int unsigned CTRL_W = 4;

    logic              Clk = 1'b0;
    logic              Reset, Flush, InValid, InReady, OutValid, OutReady;
    logic [DATA_W-1:0] InData, OutData;
    logic [CTRL_W-1:0] InCtrl, OutCtrl;
    logic [1:0]        Count;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .InData(InData), .InCtrl(InCtrl),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutCtrl(OutCtrl),
        .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control bits for a small payload value are its low nibble.
    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
        InValid  = iv;
        InData   = d;
        InCtrl   = d[CTRL_W-1:0];
        OutReady = ordy;
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                           input logic [1:0] cnt, input logic rdy);
        check({tag, ".valid"}, 128'(OutValid), 128'(v));
        check({tag, ".data"},  128'(OutData),  128'(d));
        check({tag, ".ctrl"},  128'(OutCtrl),  v ? 128'(d[CTRL_W-1:0]) : 128'(0));
        check({tag, ".count"}, 128'(Count),    128'(cnt));
        check({tag, ".ready"}, 128'(InReady),  128'(rdy));
    endtask

    initial begin
        Reset = 1'b1;
        Flush = 1'b0;
        drive(1'b1, 69'd0, 1'b0);
        #2;
        check("rst.inready_low", 128'(InReady), 128'(0));
        tick();
        tick();
        chk_out("rst", 1'b0, 69'd0, 2'd0, 1'b0);
        Reset = 1'b0;
        drive(1'b0, 69'd0, 1'b1);
        #1;
        check("rst.inready_after", 128'(InReady), 128'(1));

        // First transfer with a wide payload and a non-trivial control word.
        drive(1'b1, 69'h1_2345_6789_ABCD_EF01, 1'b1);
        tick();
        chk_out("first", 1'b1, 69'h1_2345_6789_ABCD_EF01, 2'd1, 1'b1);
        drive(1'b0, 69'd0, 1'b1);
        tick();
        check("bubble.valid", 128'(OutValid), 128'(0));
        check("bubble.ctrl",  128'(OutCtrl),  128'(0));
        check("bubble.hold",  128'(OutData),  128'(69'h1_2345_6789_ABCD_EF01));

`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 69'd1, 1'b0); tick(); chk_out("bp1", 1'b1, 69'd1, 2'd1, 1'b1);
        drive(1'b1, 69'd2, 1'b0); tick(); chk_out("bp2", 1'b1, 69'd1, 2'd2, 1'b0);
        drive(1'b1, 69'd3, 1'b0); tick(); chk_out("bp3", 1'b1, 69'd1, 2'd2, 1'b0);
        drive(1'b1, 69'd3, 1'b1); tick(); chk_out("dr2", 1'b1, 69'd2, 2'd1, 1'b1);
        tick();                           chk_out("dr3", 1'b1, 69'd3, 2'd1, 1'b1);
        drive(1'b1, 69'd4, 1'b1); tick(); chk_out("dr4", 1'b1, 69'd4, 2'd1, 1'b1);
        drive(1'b0, 69'd0, 1'b1); tick(); chk_out("drE", 1'b0, 69'd4, 2'd0, 1'b1);

        drive(1'b1, 69'd5, 1'b0); tick();
        drive(1'b1, 69'd6, 1'b0); tick(); chk_out("full", 1'b1, 69'd5, 2'd2, 1'b0);
        Flush = 1'b1;
        drive(1'b1, 69'd7, 1'b1); tick(); chk_out("flush", 1'b0, 69'd5, 2'd0, 1'b1);
        Flush = 1'b0;
        drive(1'b1, 69'd8, 1'b1); tick(); chk_out("postfl", 1'b1, 69'd8, 2'd1, 1'b1);
        drive(1'b0, 69'd0, 1'b1); tick(); chk_out("postfl2", 1'b0, 69'd8, 2'd0, 1'b1);
`else
        drive(1'b1, 69'd1, 1'b0); tick(); chk_out("bp1", 1'b1, 69'd1, 2'd1, 1'b0);
        drive(1'b1, 69'd2, 1'b0); tick(); chk_out("bp2", 1'b1, 69'd1, 2'd1, 1'b0);
        tick();                           chk_out("bp3", 1'b1, 69'd1, 2'd1, 1'b0);
        drive(1'b1, 69'd2, 1'b1);
        #1;
        check("comb.inready", 128'(InReady), 128'(1));
        tick();                           chk_out("dr2", 1'b1, 69'd2, 2'd1, 1'b1);
        drive(1'b1, 69'd3, 1'b1); tick(); chk_out("dr3", 1'b1, 69'd3, 2'd1, 1'b1);
        drive(1'b1, 69'd4, 1'b1); tick(); chk_out("dr4", 1'b1, 69'd4, 2'd1, 1'b1);
        drive(1'b0, 69'd0, 1'b1); tick(); chk_out("drE", 1'b0, 69'd4, 2'd0, 1'b1);

        drive(1'b1, 69'd5, 1'b0); tick(); chk_out("one", 1'b1, 69'd5, 2'd1, 1'b0);
        Flush = 1'b1;
        drive(1'b1, 69'd7, 1'b1); tick(); chk_out("flush", 1'b0, 69'd5, 2'd0, 1'b1);
        Flush = 1'b0;
        drive(1'b0, 69'd0, 1'b1); tick(); chk_out("postfl", 1'b0, 69'd5, 2'd0, 1'b1);
`endif

        // Mid-operation reset with an offered entry, then reset together with flush.
        drive(1'b1, 69'd9, 1'b0); tick();
        check("pre_rst.count", 128'(Count), 128'(1));
        Reset = 1'b1;
        drive(1'b1, 69'd10, 1'b1);
        #1;
        check("midrst.inready", 128'(InReady), 128'(0));
        tick();
        chk_out("midrst", 1'b0, 69'd0, 2'd0, 1'b0);
        Reset = 1'b0;
        drive(1'b0, 69'd0, 1'b1);
        #1;
        check("midrst.inready_after", 128'(InReady), 128'(1));
        drive(1'b1, 69'd11, 1'b0); tick();
        Reset = 1'b1;
        Flush = 1'b1;
        tick();
        chk_out("rstfl", 1'b0, 69'd0, 2'd0, 1'b0);
        Reset = 1'b0;
        Flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
